demux_1_to_3_8: RTL and testbench

Registered 1-to-3 demultiplexer for the datapath's 8-bit buses. It captures a source value into one of three destination holding registers, chosen by one-hot select strobes, and holds every unselected destination. It uses the same select priority as the datapath's 2-to-1 and 3-to-1 multiplexers, so a select pattern that picks operand N on the read side also routes to slot N on the write side. Each slot carries a valid/ack handshake, so downstream consumers see each written value exactly once.

---
 rtl/demux_1_to_3_8.sv | 158 +++++++++++++++
 tb/tb_demux_1_to_3_8.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/demux_1_to_3_8.sv
// Registered 1-to-3 demultiplexer with a per-slot valid/ack handshake.
//
// A source value is captured into one of three holding slots chosen by
// prioritised select strobes (first > second > third), matching the read-side
// mux priority so that select pattern N always maps to slot N. Each slot runs
// a two-state EMPTY/FULL machine so consumers see every written value once.
//
// Ports:
//   i_clk, i_rst                 rising-edge clock, async active-high reset
//   i_data_in [WIDTH]            value to route
//   i_sel_first/second/third     write strobes, first has highest priority
//   i_ack_first/second/third     consumer has taken the slot value
//   o_out_first/second/third     slot data registers (never cleared by ack)
//   o_valid_first/second/third   slot holds an unconsumed value
//   o_pending [2]                number of valid slots
//   o_collision                  one-cycle pulse after a multi-select edge
//   o_overwrite                  sticky: an unconsumed value was lost
module demux_1_to_3_8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_sel_first,
  input  logic             i_sel_second,
  input  logic             i_sel_third,
  input  logic             i_ack_first,
  input  logic             i_ack_second,
  input  logic             i_ack_third,
  output logic [WIDTH-1:0] o_out_first,
  output logic [WIDTH-1:0] o_out_second,
  output logic [WIDTH-1:0] o_out_third,
  output logic             o_valid_first,
  output logic             o_valid_second,
  output logic             o_valid_third,
  output logic [1:0]       o_pending,
  output logic             o_collision,
  output logic             o_overwrite
);

  localparam int unsigned NumSlots = 3;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } slot_state_e;

  // Slot state and data.
  slot_state_e      r_state   [NumSlots];
  slot_state_e      w_state_d [NumSlots];
  logic [WIDTH-1:0] r_data    [NumSlots];
  logic [WIDTH-1:0] w_data_d  [NumSlots];

  // Status registers.
  logic       r_collision;
  logic       w_collision_d;
  logic       r_overwrite;
  logic       w_overwrite_d;
  logic [1:0] r_pending;
  logic [1:0] w_pending_d;

  // Decoded per-slot controls.
  logic [NumSlots-1:0] w_sel;
  logic [NumSlots-1:0] w_ack;
  logic [NumSlots-1:0] w_win;
  logic [NumSlots-1:0] w_lost;
  logic [NumSlots-1:0] w_valid_d;

  assign w_sel = {i_sel_third, i_sel_second, i_sel_first};
  assign w_ack = {i_ack_third, i_ack_second, i_ack_first};

  // Priority winner: at most one bit set. Lower selects are masked by any
  // higher one so only a single slot is ever written per edge.
  always_comb begin
    w_win    = '0;
    w_win[0] = w_sel[0];
    w_win[1] = w_sel[1] & ~w_sel[0];
    w_win[2] = w_sel[2] & ~w_sel[1] & ~w_sel[0];
  end

  // Two or more selects high on the same edge.
  assign w_collision_d = (w_sel[0] & w_sel[1]) | (w_sel[0] & w_sel[2]) |
                         (w_sel[1] & w_sel[2]);

  // Per-slot next-state and data.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      w_state_d[i] = r_state[i];
      w_data_d[i]  = r_data[i];
      w_lost[i]    = 1'b0;

      if (w_win[i]) begin
        w_data_d[i] = i_data_in;
      end

      unique case (r_state[i])
        StEmpty: begin
          // An ack on an empty slot is ignored; it is not an error.
          if (w_win[i]) begin
            w_state_d[i] = StFull;
          end
        end
        StFull: begin
          if (w_win[i]) begin
            // Refill: only a loss if the old value was not taken this edge.
            w_state_d[i] = StFull;
            w_lost[i]    = ~w_ack[i];
          end else if (w_ack[i]) begin
            w_state_d[i] = StEmpty;
          end
        end
        default: begin
          w_state_d[i] = StEmpty;
        end
      endcase

      w_valid_d[i] = (w_state_d[i] == StFull);
    end
  end

  // Pending is computed from next-state valids so it tracks the valid
  // outputs on the same cycle.
  assign w_pending_d = {1'b0, w_valid_d[0]} + {1'b0, w_valid_d[1]} +
                       {1'b0, w_valid_d[2]};

  assign w_overwrite_d = r_overwrite | (|w_lost);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NumSlots; i++) begin
        r_state[i] <= StEmpty;
        r_data[i]  <= '0;
      end
      r_collision <= 1'b0;
      r_overwrite <= 1'b0;
      r_pending   <= 2'd0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        r_state[i] <= w_state_d[i];
        r_data[i]  <= w_data_d[i];
      end
      r_collision <= w_collision_d;
      r_overwrite <= w_overwrite_d;
      r_pending   <= w_pending_d;
    end
  end

  assign o_out_first    = r_data[0];
  assign o_out_second   = r_data[1];
  assign o_out_third    = r_data[2];
  assign o_valid_first  = (r_state[0] == StFull);
  assign o_valid_second = (r_state[1] == StFull);
  assign o_valid_third  = (r_state[2] == StFull);
  assign o_pending      = r_pending;
  assign o_collision    = r_collision;
  assign o_overwrite    = r_overwrite;

endmodule

// File: tb/tb_demux_1_to_3_8.sv
// Bench for demux_1_to_3_8: a table of directed vectors applied one edge
// each, followed by hand-written sequences for sticky overwrite and
// asynchronous reset.
module tb_demux_1_to_3_8;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       sel_first, sel_second, sel_third;
  logic       ack_first, ack_second, ack_third;
  logic [7:0] out_first, out_second, out_third;
  logic       valid_first, valid_second, valid_third;
  logic [1:0] pending;
  logic       collision;
  logic       overwrite;

  int total = 0;
  int bad   = 0;

  demux_1_to_3_8 #(.WIDTH(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_data_in     (data_in),
    .i_sel_first   (sel_first),
    .i_sel_second  (sel_second),
    .i_sel_third   (sel_third),
    .i_ack_first   (ack_first),
    .i_ack_second  (ack_second),
    .i_ack_third   (ack_third),
    .o_out_first   (out_first),
    .o_out_second  (out_second),
    .o_out_third   (out_third),
    .o_valid_first (valid_first),
    .o_valid_second(valid_second),
    .o_valid_third (valid_third),
    .o_pending     (pending),
    .o_collision   (collision),
    .o_overwrite   (overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel/ack/valid bit 0 = first, bit 2 = third.
  typedef struct {
    logic [2:0] sel;
    logic [2:0] ack;
    logic [7:0] din;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] e3;
    logic [2:0] ev;
    logic [1:0] ep;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3, input logic [2:0] ev,
                           input logic [1:0] ep, input logic ec, input logic eo);
    check("out_first", idx, out_first, e1);
    check("out_second", idx, out_second, e2);
    check("out_third", idx, out_third, e3);
    check("valid", idx, {5'b0, valid_third, valid_second, valid_first}, {5'b0, ev});
    check("pending", idx, {6'b0, pending}, {6'b0, ep});
    check("collision", idx, {7'b0, collision}, {7'b0, ec});
    check("overwrite", idx, {7'b0, overwrite}, {7'b0, eo});
  endtask

  task automatic drive(input logic [2:0] sel, input logic [2:0] ack, input logic [7:0] din);
    {sel_third, sel_second, sel_first} = sel;
    {ack_third, ack_second, ack_first} = ack;
    data_in = din;
  endtask

  // Drive at the falling edge, let one rising edge sample, look 1 unit later.
  task automatic step(input logic [2:0] sel, input logic [2:0] ack, input logic [7:0] din);
    @(negedge clk);
    drive(sel, ack, din);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            sel     ack     din    e1     e2     e3     ev      ep  ec  eo
    vecs[0]  = '{3'b001, 3'b000, 8'hA5, 8'hA5, 8'h00, 8'h00, 3'b001, 1, 0, 0};
    vecs[1]  = '{3'b010, 3'b000, 8'h11, 8'hA5, 8'h11, 8'h00, 3'b011, 2, 0, 0};
    vecs[2]  = '{3'b000, 3'b010, 8'hEE, 8'hA5, 8'h11, 8'h00, 3'b001, 1, 0, 0};
    // All selects: first wins (acked so no loss), collision pulses.
    vecs[3]  = '{3'b111, 3'b001, 8'h3C, 8'h3C, 8'h11, 8'h00, 3'b001, 1, 1, 0};
    vecs[4]  = '{3'b000, 3'b000, 8'h99, 8'h3C, 8'h11, 8'h00, 3'b001, 1, 0, 0};
    vecs[5]  = '{3'b000, 3'b001, 8'h00, 8'h3C, 8'h11, 8'h00, 3'b000, 0, 0, 0};
    // Ack on an empty slot is ignored.
    vecs[6]  = '{3'b000, 3'b100, 8'h00, 8'h3C, 8'h11, 8'h00, 3'b000, 0, 0, 0};
    vecs[7]  = '{3'b100, 3'b000, 8'h55, 8'h3C, 8'h11, 8'h55, 3'b100, 1, 0, 0};
    // Refill with ack on the same edge: no error.
    vecs[8]  = '{3'b100, 3'b100, 8'h78, 8'h3C, 8'h11, 8'h78, 3'b100, 1, 0, 0};
    // Second beats third.
    vecs[9]  = '{3'b110, 3'b000, 8'h22, 8'h3C, 8'h22, 8'h78, 3'b110, 2, 1, 0};
    // Refill without ack: overwrite sets.
    vecs[10] = '{3'b100, 3'b000, 8'h77, 8'h3C, 8'h22, 8'h77, 3'b110, 2, 0, 1};
    vecs[11] = '{3'b000, 3'b110, 8'h00, 8'h3C, 8'h22, 8'h77, 3'b000, 0, 0, 1};
    // Write with ack on an empty slot still fills it.
    vecs[12] = '{3'b001, 3'b001, 8'h5A, 8'h5A, 8'h22, 8'h77, 3'b001, 1, 0, 1};

    rst = 1'b1;
    drive(3'b000, 3'b000, 8'h00);
    #12;
    check_all(100, 8'h00, 8'h00, 8'h00, 3'b000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].sel, vecs[i].ack, vecs[i].din);
      check_all(i, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].ev, vecs[i].ep,
                vecs[i].ec, vecs[i].eo);
    end

    // Overwrite is sticky across idle cycles.
    for (int i = 0; i < 10; i++) begin
      step(3'b000, 3'b000, 8'h00);
      check("overwrite_sticky", i, {7'b0, overwrite}, 8'h01);
    end

    // Fill all three slots.
    step(3'b001, 3'b001, 8'hF1);
    step(3'b010, 3'b000, 8'hF2);
    step(3'b100, 3'b000, 8'hF3);
    check_all(200, 8'hF1, 8'hF2, 8'hF3, 3'b111, 2'd3, 1'b0, 1'b1);

    // Asynchronous reset between edges clears everything at once.
    #2;
    rst = 1'b1;
    #1;
    check_all(201, 8'h00, 8'h00, 8'h00, 3'b000, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    drive(3'b010, 3'b000, 8'h01);
    @(posedge clk);
    #1;
    check_all(202, 8'h00, 8'h01, 8'h00, 3'b010, 2'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
